rv_bus_arbiter: RTL and testbench

//  Two-master round-robin arbiter sharing the single data bus (store/load port) between the
//  RV32I core (master 0) and a DMA/debug requester (master 1). Sequences one transaction at a

---
 rtl/rv_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_rv_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_bus_arbiter.sv
// Two-master round-robin bus arbiter: one transaction at a time onto a sel/ready slave
// handshake, with read-data return and a slave-wait timeout that completes with an error.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transfer in flight; arbitrate on any m_req
// BUSY  | s_sel high, waiting for s_ready or for the timeout to expire
// RESP  | one-cycle m_ready/m_err pulse to the granted master
module rv_bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          m_req,
   input  logic [1:0]          m_we,
   input  logic [2*ADDR_W-1:0] m_addr,
   input  logic [2*DATA_W-1:0] m_wdata,
   output logic [1:0]          m_ready,
   output logic [1:0]          m_err,
   output logic [DATA_W-1:0]   m_rdata,
   output logic                s_sel,
   output logic                s_we,
   output logic [ADDR_W-1:0]   s_addr,
   output logic [DATA_W-1:0]   s_wdata,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic                s_ready,
   output logic                grant_id
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } state_t;

   state_t              state, state_n;
   logic                last_grant, last_grant_n;
   logic [CNT_W-1:0]    tout_cnt, tout_cnt_n;
   logic                grant_id_n;
   logic                s_sel_n;
   logic                s_we_n;
   logic [ADDR_W-1:0]   s_addr_n;
   logic [DATA_W-1:0]   s_wdata_n;
   logic [1:0]          m_ready_n;
   logic [1:0]          m_err_n;
   logic [DATA_W-1:0]   m_rdata_n;
   logic                winner;
   logic [1:0]          grant_onehot;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_IDLE;
         last_grant <= 1'b1;
         tout_cnt   <= '0;
         grant_id   <= 1'b0;
         s_sel      <= 1'b0;
         s_we       <= 1'b0;
         s_addr     <= '0;
         s_wdata    <= '0;
         m_ready    <= '0;
         m_err      <= '0;
         m_rdata    <= '0;
      end else begin
         state      <= state_n;
         last_grant <= last_grant_n;
         tout_cnt   <= tout_cnt_n;
         grant_id   <= grant_id_n;
         s_sel      <= s_sel_n;
         s_we       <= s_we_n;
         s_addr     <= s_addr_n;
         s_wdata    <= s_wdata_n;
         m_ready    <= m_ready_n;
         m_err      <= m_err_n;
         m_rdata    <= m_rdata_n;
      end
   end

   always_comb begin
      state_n      = state;
      last_grant_n = last_grant;
      tout_cnt_n   = tout_cnt;
      grant_id_n   = grant_id;
      s_sel_n      = s_sel;
      s_we_n       = s_we;
      s_addr_n     = s_addr;
      s_wdata_n    = s_wdata;
      m_ready_n    = '0;
      m_err_n      = '0;
      m_rdata_n    = m_rdata;
      // on a tie the master that did not win last time gets the bus
      winner       = (m_req == 2'b11) ? ~last_grant : m_req[1];
      grant_onehot = grant_id ? 2'b10 : 2'b01;

      case (state)
         ST_IDLE: begin
            s_sel_n = 1'b0;
            if (|m_req) begin
               s_sel_n      = 1'b1;
               s_we_n       = winner ? m_we[1] : m_we[0];
               s_addr_n     = winner ? m_addr[2*ADDR_W-1:ADDR_W] : m_addr[ADDR_W-1:0];
               s_wdata_n    = winner ? m_wdata[2*DATA_W-1:DATA_W] : m_wdata[DATA_W-1:0];
               grant_id_n   = winner;
               last_grant_n = winner;
               tout_cnt_n   = '0;
               state_n      = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // s_ready takes priority over a timeout expiring in the same cycle
            if (s_ready) begin
               m_rdata_n = s_we ? '0 : s_rdata;
               m_ready_n = grant_onehot;
               s_sel_n   = 1'b0;
               state_n   = ST_RESP;
            end else if (tout_cnt >= TOUT_LAST) begin
               m_rdata_n = '0;
               m_ready_n = grant_onehot;
               m_err_n   = grant_onehot;
               s_sel_n   = 1'b0;
               state_n   = ST_RESP;
            end else begin
               tout_cnt_n = tout_cnt + CNT_W'(1);
            end
         end
         ST_RESP: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
            s_sel_n = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_rv_bus_arbiter.sv
// Bench for rv_bus_arbiter: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level reference model.
module tb_rv_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      m_req, m_we, m_ready, m_err;
   logic [2*AW-1:0] m_addr;
   logic [2*DW-1:0] m_wdata;
   logic [DW-1:0]   m_rdata, s_wdata, s_rdata;
   logic [AW-1:0]   s_addr;
   logic            s_sel, s_we, s_ready, grant_id;

   int tests = 0;
   int fails = 0;

   rv_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(rst),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ready(m_ready), .m_err(m_err), .m_rdata(m_rdata),
      .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .s_ready(s_ready), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: one transaction record (who, what, how long it has waited)
   bit              mvalid = 1'b0;
   int              phase;      // 0 idle, 1 waiting on slave, 2 answering master
   bit              last;
   int              waited;
   logic [1:0]      e_ready, e_err;
   logic [DW-1:0]   e_rdata, e_wdata;
   logic [AW-1:0]   e_addr;
   logic            e_sel, e_we, e_gid;

   task automatic model_complete(input bit err);
      e_sel   = 1'b0;
      e_ready = 2'b01 << e_gid;
      e_err   = err ? e_ready : 2'b00;
      phase   = 2;
   endtask

   always @(posedge clk) begin
      if (!rst) begin
         mvalid = 1'b1; phase = 0; last = 1'b1; waited = 0;
         e_ready = '0; e_err = '0; e_rdata = '0; e_sel = 1'b0; e_we = 1'b0;
         e_addr = '0; e_wdata = '0; e_gid = 1'b0;
      end else if (mvalid) begin
         if (phase == 0) begin
            if (m_req != 2'b00) begin
               int w;
               w       = (m_req == 2'b11) ? (last ? 0 : 1) : (m_req[1] ? 1 : 0);
               last    = (w == 1);
               e_gid   = (w == 1);
               e_sel   = 1'b1;
               e_we    = m_we[w];
               e_addr  = m_addr[w*AW +: AW];
               e_wdata = m_wdata[w*DW +: DW];
               waited  = 0;
               phase   = 1;
            end
         end else if (phase == 1) begin
            waited++;
            if (s_ready) begin
               e_rdata = e_we ? '0 : s_rdata;
               model_complete(1'b0);
            end else if (waited == TO) begin
               e_rdata = '0;
               model_complete(1'b1);
            end
         end else begin
            e_ready = '0;
            e_err   = '0;
            phase   = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (mvalid) begin
         chk("m_ready",  64'(m_ready),  64'(e_ready));
         chk("m_err",    64'(m_err),    64'(e_err));
         chk("m_rdata",  64'(m_rdata),  64'(e_rdata));
         chk("s_sel",    64'(s_sel),    64'(e_sel));
         chk("s_we",     64'(s_we),     64'(e_we));
         chk("s_addr",   64'(s_addr),   64'(e_addr));
         chk("s_wdata",  64'(s_wdata),  64'(e_wdata));
         chk("grant_id", 64'(grant_id), 64'(e_gid));
      end
   end

   int cnt;
   int pct;

   initial begin
      rst = 1'b0; m_req = 2'b11; m_we = '0; m_addr = '0; m_wdata = '0;
      s_ready = 1'b0; s_rdata = '0;

      repeat (2) begin
         @(negedge clk);
         chk("rst_s_sel", 64'(s_sel), 64'd0);
         chk("rst_m_ready", 64'(m_ready), 64'd0);
         chk("rst_grant", 64'(grant_id), 64'd0);
         chk("rst_rdata", 64'(m_rdata), 64'd0);
      end

      // single read from master 0
      rst = 1'b1; m_req = 2'b01; m_we = 2'b00; m_addr[0 +: AW] = 32'h0000_1000;
      @(negedge clk);
      chk("rd_sel", 64'(s_sel), 64'd1);
      chk("rd_addr", 64'(s_addr), 64'h1000);
      s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("rd_ready", 64'(m_ready), 64'd1);
      chk("rd_data", 64'(m_rdata), 64'hDEAD_BEEF);
      chk("rd_sel_drop", 64'(s_sel), 64'd0);
      m_req = 2'b00; s_ready = 1'b0;
      @(negedge clk);
      chk("rd_ready_pulse", 64'(m_ready), 64'd0);

      // contention after a fresh reset: strict alternation starting at master 0
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1; m_req = 2'b11; m_we = 2'b10;
      m_addr = {32'h0000_3000, 32'h0000_2000}; m_wdata = {32'h1234_5678, 32'h0};
      s_ready = 1'b1; s_rdata = 32'h0000_0055;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("ct_grant", 64'(grant_id), 64'(k % 2));
         chk("ct_sel", 64'(s_sel), 64'd1);
         if (k % 2 == 1) begin
            chk("ct_we", 64'(s_we), 64'd1);
            chk("ct_wdata", 64'(s_wdata), 64'h1234_5678);
         end
         @(negedge clk);
         chk("ct_ready", 64'(m_ready), (k % 2 == 1) ? 64'd2 : 64'd1);
         chk("ct_rdata", 64'(m_rdata), (k % 2 == 1) ? 64'd0 : 64'h55);
         if (k == 3) m_req = 2'b00;
         @(negedge clk);
      end

      // timeout on master 1 read
      s_ready = 1'b0; m_we = 2'b00; m_req = 2'b10; cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (s_sel) cnt++;
         if (m_ready != 2'b00) break;
      end
      chk("to_sel_cycles", 64'(cnt), 64'd16);
      chk("to_ready", 64'(m_ready), 64'd2);
      chk("to_err", 64'(m_err), 64'd2);
      chk("to_rdata", 64'(m_rdata), 64'd0);
      m_req = 2'b00;
      @(negedge clk);

      // s_ready on the last allowed cycle beats the timeout
      m_req = 2'b10; s_rdata = 32'hCAFE_0001; cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (s_sel) begin
            cnt++;
            if (cnt == 16) s_ready = 1'b1;
         end
         if (m_ready != 2'b00) break;
      end
      chk("tl_sel_cycles", 64'(cnt), 64'd16);
      chk("tl_ready", 64'(m_ready), 64'd2);
      chk("tl_err", 64'(m_err), 64'd0);
      chk("tl_rdata", 64'(m_rdata), 64'hCAFE_0001);
      m_req = 2'b00; s_ready = 1'b0;
      @(negedge clk);

      // reset in the third BUSY cycle
      m_req = 2'b10;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rm_sel", 64'(s_sel), 64'd0);
      chk("rm_ready", 64'(m_ready), 64'd0);
      rst = 1'b1; m_req = 2'b11;
      @(negedge clk);
      chk("rm_grant", 64'(grant_id), 64'd0);
      chk("rm_sel_on", 64'(s_sel), 64'd1);
      m_req = 2'b00; s_ready = 1'b1;
      @(negedge clk);
      chk("rm_done", 64'(m_ready), 64'd1);
      s_ready = 1'b0;
      @(negedge clk);

      // back-to-back transfers from master 0 with a fresh address
      m_req = 2'b01; m_addr[0 +: AW] = 32'h0000_00A0; s_ready = 1'b1; s_rdata = 32'h77;
      @(negedge clk);
      chk("bb_addr1", 64'(s_addr), 64'hA0);
      @(negedge clk);
      chk("bb_ready1", 64'(m_ready), 64'd1);
      m_addr[0 +: AW] = 32'h0000_00B0;
      @(negedge clk);
      chk("bb_idle", 64'(s_sel), 64'd0);
      @(negedge clk);
      chk("bb_sel2", 64'(s_sel), 64'd1);
      chk("bb_addr2", 64'(s_addr), 64'hB0);
      m_req = 2'b00;
      @(negedge clk);
      chk("bb_ready2", 64'(m_ready), 64'd1);
      s_ready = 1'b0;
      @(negedge clk);

      // randomized traffic; the per-cycle compare process does the checking
      pct = 50;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (c % 128 == 0) begin
            case ($urandom_range(0, 3))
               0: pct = 100;
               1: pct = 50;
               2: pct = 10;
               default: pct = 0;
            endcase
         end
         rst = ($urandom_range(0, 299) != 0);
         for (int i = 0; i < 2; i++) begin
            if (m_req[i]) begin
               if (m_ready[i]) m_req[i] = ($urandom_range(0, 1) == 1);
               else if ($urandom_range(0, 63) == 0) m_req[i] = 1'b0;
            end else begin
               m_req[i] = ($urandom_range(0, 2) == 0);
            end
         end
         m_we    = 2'($urandom());
         m_addr  = {32'($urandom()), 32'($urandom())};
         m_wdata = {32'($urandom()), 32'($urandom())};
         s_rdata = 32'($urandom());
         s_ready = ($urandom_range(0, 99) < pct);
      end

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
